// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state
// encoding, the bubble instruction and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] INST_STEP = 32'd4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch-stage performance counters: completed fetches and cycles spent
// stalled. Both clear on reset and wrap naturally at 2^32.
module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        stall_en,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    // Count qualifying events each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_en) fetch_count <= fetch_count + 32'd1;
            if (stall_en) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction
// memory address and registers the fetched word into the IF/ID outputs.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] inst_data,
    output logic [31:0] inst_addr,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic [1:0]  state
);

    localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

    // Sequential PCs wrap inside the instruction memory.
    function automatic logic [31:0] wrap_pc(input logic [31:0] addr);
        return addr & PC_MASK;
    endfunction

    // Redirect targets are forced to a word boundary, then wrapped.
    function automatic logic [31:0] align_target(input logic [31:0] addr);
        return wrap_pc({addr[31:2], 2'b00});
    endfunction

    fetch_state_t state_p0;
    logic [31:0]  pc_p0;
    logic [31:0]  if_inst_p1;
    logic [31:0]  if_pc_p1;
    logic [31:0]  if_pc_plus4_p1;
    logic         vld_p1;

    logic active;
    logic do_branch;
    logic do_hold;
    logic do_fetch;

    // IDLE ignores stall and branch; elsewhere a branch outranks stall.
    always_comb begin
        active    = (state_p0 != IDLE);
        do_branch = active && branch_taken;
        do_hold   = active && !branch_taken && stall;
        do_fetch  = active && !branch_taken && !stall;
    end

    // Fetch FSM with the PC and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0       <= IDLE;
            pc_p0          <= RESET_PC;
            if_inst_p1     <= NOP;
            if_pc_p1       <= '0;
            if_pc_plus4_p1 <= '0;
            vld_p1         <= 1'b0;
        end else if (state_p0 == IDLE) begin
            state_p0 <= RUN;
        end else if (do_branch) begin
            pc_p0      <= align_target(branch_target);
            if_inst_p1 <= NOP;
            vld_p1     <= 1'b0;
            state_p0   <= FLUSH;
        end else if (do_hold) begin
            state_p0 <= STALL;
        end else begin
            // IF/ID stage boundary: capture the word addressed this cycle.
            if_inst_p1     <= inst_data;
            if_pc_p1       <= pc_p0;
            if_pc_plus4_p1 <= pc_p0 + INST_STEP;
            vld_p1         <= 1'b1;
            pc_p0          <= wrap_pc(pc_p0 + INST_STEP);
            state_p0       <= RUN;
        end
    end

    assign inst_addr   = pc_p0;
    assign if_inst     = if_inst_p1;
    assign if_pc       = if_pc_p1;
    assign if_pc_plus4 = if_pc_plus4_p1;
    assign if_valid    = vld_p1;
    assign state       = state_p0;

`ifdef FETCH_PERF_EN
    logic stall_cycle;
    assign stall_cycle = (state_p0 == STALL);

    fetch_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (do_fetch),
        .stall_en    (stall_cycle),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a small combinational
// instruction memory. A second instance with MEM_BYTES=16 covers wrap.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, inst_data;
    logic [31:0] inst_addr, if_inst, if_pc, if_pc_plus4;
    logic        if_valid;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
    logic [31:0] fetch_count16, stall_count16;
`endif

    logic        reset16;
    logic [31:0] inst_data16, inst_addr16, if_inst16, if_pc16, if_pc_plus4_16;
    logic        if_valid16;
    logic [1:0]  state16;

    logic [31:0] inst_memory [0:255];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inst_data   = inst_memory[inst_addr[9:2]];
    assign inst_data16 = inst_memory[inst_addr16[9:2]];

    fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .inst_data     (inst_data),
        .inst_addr     (inst_addr),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_valid      (if_valid),
`ifdef FETCH_PERF_EN
        .fetch_count   (fetch_count),
        .stall_count   (stall_count),
`endif
        .state         (state)
    );

    fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(16)) dut16 (
        .clk           (clk),
        .reset         (reset16),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .inst_data     (inst_data16),
        .inst_addr     (inst_addr16),
        .if_inst       (if_inst16),
        .if_pc         (if_pc16),
        .if_pc_plus4   (if_pc_plus4_16),
        .if_valid      (if_valid16),
`ifdef FETCH_PERF_EN
        .fetch_count   (fetch_count16),
        .stall_count   (stall_count16),
`endif
        .state         (state16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        step(); step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", inst_addr); end
        checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL reset_outs got v=%b inst=%h pc=%h p4=%h want all 0", if_valid, if_inst, if_pc, if_pc_plus4);
        end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
            errors++; $display("FAIL reset_cnt got f=%0d s=%0d want 0", fetch_count, stall_count);
        end
`endif
        stall = 1'b0; branch_taken = 1'b0;
    endtask

    // Release from reset with stall/branch high: IDLE ignores them.
    task automatic test_idle_ignore();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        reset = 1'b0;
        step();
        checks++; if (state !== 2'd1 || inst_addr !== 32'h0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ignore got st=%0d addr=%h v=%b want 1 0 0", state, inst_addr, if_valid);
        end
        stall = 1'b0; branch_taken = 1'b0;
        reset = 1'b1; step();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_inst [0:2];
        exp_inst[0] = 32'h00A60820; exp_inst[1] = 32'h21420002; exp_inst[2] = 32'h21830001;
        reset = 1'b0;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_idle got v=%b want 0", if_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_inst !== exp_inst[i]) begin
                errors++; $display("FAIL seq_%0d got v=%b pc=%h inst=%h want 1 %h %h", i, if_valid, if_pc, if_inst, 4 * i, exp_inst[i]);
            end
        end
        checks++; if (if_pc_plus4 !== 32'hC) begin errors++; $display("FAIL seq_p4 got %h want c", if_pc_plus4); end
    endtask

    task automatic test_stall();
        reset = 1'b1; step();
        reset = 1'b0; step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_inst !== 32'h21420002 || if_pc !== 32'h4 || inst_addr !== 32'h8 || state !== 2'd2) begin
                errors++; $display("FAIL stall_%0d got inst=%h pc=%h addr=%h st=%0d want 21420002 4 8 2", i, if_inst, if_pc, inst_addr, state);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (if_inst !== 32'h21830001 || if_pc !== 32'h8 || state !== 2'd1) begin
            errors++; $display("FAIL stall_release got inst=%h pc=%h st=%0d want 21830001 8 1", if_inst, if_pc, state);
        end
`ifdef FETCH_PERF_EN
        checks++; if (stall_count !== 32'd3 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL stall_cnt got s=%0d f=%0d want 3 3", stall_count, fetch_count);
        end
`endif
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h12;
        step();
        checks++; if (if_valid !== 1'b0 || state !== 2'd3 || inst_addr !== 32'h10 || if_inst !== 32'h0) begin
            errors++; $display("FAIL br_flush got v=%b st=%0d addr=%h inst=%h want 0 3 10 0", if_valid, state, inst_addr, if_inst);
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        checks++; if (if_inst !== 32'h02852822 || if_pc !== 32'h10 || if_valid !== 1'b1 || if_pc_plus4 !== 32'h14) begin
            errors++; $display("FAIL br_target got inst=%h pc=%h v=%b p4=%h want 02852822 10 1 14", if_inst, if_pc, if_valid, if_pc_plus4);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [0:4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC; exp_pc[4] = 32'h0;
        reset16 = 1'b1; step();
        reset16 = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (if_pc16 !== exp_pc[i] || if_pc_plus4_16 !== exp_pc[i] + 32'd4 || if_valid16 !== 1'b1
                          || if_inst16 !== inst_memory[exp_pc[i][9:2]]) begin
                errors++; $display("FAIL wrap_%0d got pc=%h p4=%h v=%b inst=%h want %h %h 1 %h", i, if_pc16, if_pc_plus4_16,
                                   if_valid16, if_inst16, exp_pc[i], exp_pc[i] + 32'd4, inst_memory[exp_pc[i][9:2]]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        reset = 1'b1; step();
        reset = 1'b0; step();
        for (int i = 0; i < 4; i++) step();
        checks++; if (if_pc !== 32'hC) begin errors++; $display("FAIL rms_setup got pc=%h want c", if_pc); end
        stall = 1'b1; step();
        reset = 1'b1; step();
        checks++; if (state !== 2'd0 || inst_addr !== 32'h0 || if_valid !== 1'b0 || if_inst !== 32'h0
                      || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL rms_clear got st=%0d addr=%h v=%b inst=%h pc=%h p4=%h want all 0",
                               state, inst_addr, if_valid, if_inst, if_pc, if_pc_plus4);
        end
        reset = 1'b0; stall = 1'b0;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rms_idle got v=%b want 0", if_valid); end
        step();
        checks++; if (if_valid !== 1'b1 || if_inst !== 32'h00A60820 || if_pc !== 32'h0) begin
            errors++; $display("FAIL rms_first got v=%b inst=%h pc=%h want 1 00a60820 0", if_valid, if_inst, if_pc);
        end
    endtask

    task automatic test_back_to_back();
        branch_taken = 1'b1; branch_target = 32'h14;
        step();
        checks++; if (if_valid !== 1'b0 || state !== 2'd3 || inst_addr !== 32'h14) begin
            errors++; $display("FAIL b2b_first got v=%b st=%0d addr=%h want 0 3 14", if_valid, state, inst_addr);
        end
        branch_target = 32'h04;
        step();
        checks++; if (if_valid !== 1'b0 || state !== 2'd3 || inst_addr !== 32'h4) begin
            errors++; $display("FAIL b2b_second got v=%b st=%0d addr=%h want 0 3 4", if_valid, state, inst_addr);
        end
        branch_taken = 1'b0;
        step();
        checks++; if (if_valid !== 1'b1 || if_inst !== 32'h21420002 || if_pc !== 32'h4) begin
            errors++; $display("FAIL b2b_land got v=%b inst=%h pc=%h want 1 21420002 4", if_valid, if_inst, if_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) inst_memory[i] = 32'hDEAD_0000 | 32'(i);
        inst_memory[0] = 32'h00A60820;
        inst_memory[1] = 32'h21420002;
        inst_memory[2] = 32'h21830001;
        inst_memory[3] = 32'h008A2020;
        inst_memory[4] = 32'h02852822;
        inst_memory[5] = 32'h03083023;
        reset = 1'b1; reset16 = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

        test_reset();
        test_idle_ignore();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_wrap();
        test_reset_mid_stall();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
